// File: rtl/mfcc_ctrl_pkg.sv
// mfcc_ctrl_pkg: shared frame-sequencer state type, default widths and the "unlimited frames" constant
package mfcc_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_WIN, WAIT_HAM, WAIT_FFT, WAIT_CONS, ADVANCE} seq_state_t;
  localparam int FRAME_CNT_WIDTH_DEF = 16;
  localparam int WDT_CYCLES_DEF = 65535;
  localparam int UNLIMITED_FRAMES = 0;
endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: per-stage dwell counter (clr restarts it, saturates at WDT_CYCLES); expired flags the last allowed cycle while en
module stage_watchdog #(
  parameter int WDT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(WDT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (cnt == W'(WDT_CYCLES) ? cnt : cnt + W'(1));
  assign expired = en && cnt == W'(WDT_CYCLES - 1);
endmodule

// File: rtl/mfcc_frame_sequencer.sv
// mfcc_frame_sequencer: orders win->ham->fft->consumer per frame; in run_i/stop_i/win_ready_i/win_idle_i/ham_done_i/fft_done_i/pwr_consumed_i, out win_move_o/ham_start_o/fft_start_o/frame_done_o pulses, frame_cnt_o, busy_o, error_o (watchdog via SEQ_WATCHDOG_EN)
module mfcc_frame_sequencer
  import mfcc_ctrl_pkg::*;
#(
  parameter int MAX_FRAMES = UNLIMITED_FRAMES,
  parameter int FRAME_CNT_WIDTH = FRAME_CNT_WIDTH_DEF,
  parameter int WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic stop_i,
  input  logic win_ready_i,
  input  logic win_idle_i,
  output logic win_move_o,
  output logic ham_start_o,
  input  logic ham_done_i,
  output logic fft_start_o,
  input  logic fft_done_i,
  input  logic pwr_consumed_i,
  output logic frame_done_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
  output logic busy_o,
  output logic error_o
);
  seq_state_t state, state_nxt;
  logic stop_pend, ham_nxt, fft_nxt, done_nxt, move_nxt, wdt_trip, at_limit, unused_in;
  logic [FRAME_CNT_WIDTH-1:0] cnt_nxt;
  assign unused_in = win_idle_i ^ (WDT_CYCLES == 0);
  assign at_limit = MAX_FRAMES != 0 && frame_cnt_o == FRAME_CNT_WIDTH'(MAX_FRAMES);
  assign busy_o = state != IDLE;
`ifdef SEQ_WATCHDOG_EN
  logic wdt_en;
  assign wdt_en = state inside {WAIT_HAM, WAIT_FFT, WAIT_CONS};
  stage_watchdog #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
    .clk(clk), .rst_n(rst_n), .clr(state_nxt != state), .en(wdt_en), .expired(wdt_trip)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) error_o <= 1'b0;
    else error_o <= wdt_trip ? 1'b1 : (state == IDLE && run_i) ? 1'b0 : error_o;
`else
  assign wdt_trip = 1'b0;
  assign error_o = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    cnt_nxt = frame_cnt_o;
    ham_nxt = 1'b0;
    fft_nxt = 1'b0;
    done_nxt = 1'b0;
    move_nxt = 1'b0;
    if (wdt_trip) state_nxt = IDLE;
    else
      case (state)
        IDLE: if (run_i) begin
          cnt_nxt = '0;
          state_nxt = WAIT_WIN;
        end
        WAIT_WIN: if (win_ready_i) begin
          ham_nxt = 1'b1;
          state_nxt = WAIT_HAM;
        end
        WAIT_HAM: if (ham_done_i) begin
          fft_nxt = 1'b1;
          state_nxt = WAIT_FFT;
        end
        WAIT_FFT: state_nxt = fft_done_i ? WAIT_CONS : WAIT_FFT;
        WAIT_CONS: if (pwr_consumed_i) begin
          done_nxt = 1'b1;
          cnt_nxt = frame_cnt_o + FRAME_CNT_WIDTH'(1);
          state_nxt = ADVANCE;
        end
        ADVANCE: begin
          move_nxt = 1'b1;
          state_nxt = (stop_pend || stop_i || !run_i || at_limit) ? IDLE : WAIT_WIN;
        end
        default: state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      stop_pend <= 1'b0;
      frame_cnt_o <= '0;
      ham_start_o <= 1'b0;
      fft_start_o <= 1'b0;
      frame_done_o <= 1'b0;
      win_move_o <= 1'b0;
    end else begin
      state <= state_nxt;
      stop_pend <= state_nxt == IDLE ? 1'b0 : stop_pend | (state != IDLE && stop_i);
      frame_cnt_o <= cnt_nxt;
      ham_start_o <= ham_nxt;
      fft_start_o <= fft_nxt;
      frame_done_o <= done_nxt;
      win_move_o <= move_nxt;
    end
endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// tb_mfcc_frame_sequencer: directed and random handshakes on an unlimited (wrapping) and a one-frame instance against a frame-level model
module tb_mfcc_frame_sequencer;
  localparam int W = 3;
  localparam int WDT = 100;
`ifdef SEQ_WATCHDOG_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0, run_i = 1'b0, stop_i = 1'b0, win_ready_i = 1'b0, win_idle_i = 1'b1;
  logic ham_done_i = 1'b0, fft_done_i = 1'b0, pwr_consumed_i = 1'b0;
  logic win_move[2], ham_start[2], fft_start[2], frame_done[2], busy[2], error[2];
  logic [W-1:0] fcnt[2];
  int n_checks = 0, n_fail = 0;
  int ph[2], cnt[2], dwell[2];
  bit pend[2], err[2], e_ham[2], e_fft[2], e_done[2], e_move[2];
  always #5 clk = ~clk;
  for (genvar i = 0; i < 2; i++) begin : g_dut
    mfcc_frame_sequencer #(.MAX_FRAMES(i), .FRAME_CNT_WIDTH(W), .WDT_CYCLES(WDT)) u_dut (
      .clk(clk), .rst_n(rst_n), .run_i(run_i), .stop_i(stop_i), .win_ready_i(win_ready_i),
      .win_idle_i(win_idle_i), .win_move_o(win_move[i]), .ham_start_o(ham_start[i]),
      .ham_done_i(ham_done_i), .fft_start_o(fft_start[i]), .fft_done_i(fft_done_i),
      .pwr_consumed_i(pwr_consumed_i), .frame_done_o(frame_done[i]), .frame_cnt_o(fcnt[i]),
      .busy_o(busy[i]), .error_o(error[i])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // ph: 0 idle, 1 awaiting window, 2 awaiting hamming, 3 awaiting fft, 4 awaiting consumer, 5 releasing window
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int old;
      old = ph[k];
      {e_ham[k], e_fft[k], e_done[k], e_move[k]} = '0;
      if (!rst_n) begin
        ph[k] = 0; cnt[k] = 0; dwell[k] = 0; pend[k] = 0; err[k] = 0;
        continue;
      end
      if (WDT_ON && old >= 2 && old <= 4 && dwell[k] == WDT - 1) begin
        err[k] = 1; ph[k] = 0;
      end else if (old == 0 && run_i) begin
        ph[k] = 1; cnt[k] = 0; err[k] = 0;
      end else if (old == 1 && win_ready_i) begin
        ph[k] = 2; e_ham[k] = 1;
      end else if (old == 2 && ham_done_i) begin
        ph[k] = 3; e_fft[k] = 1;
      end else if (old == 3 && fft_done_i) ph[k] = 4;
      else if (old == 4 && pwr_consumed_i) begin
        ph[k] = 5; e_done[k] = 1; cnt[k] = (cnt[k] + 1) % (1 << W);
      end else if (old == 5) begin
        e_move[k] = 1;
        ph[k] = (pend[k] || stop_i || !run_i || (k == 1 && cnt[k] == k)) ? 0 : 1;
      end
      pend[k] = ph[k] == 0 ? 0 : (pend[k] | (old != 0 && stop_i));
      dwell[k] = ph[k] != old ? 0 : dwell[k] + 1;
    end
  endtask
  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d ham_start", k), ham_start[k], e_ham[k]);
      check($sformatf("u%0d fft_start", k), fft_start[k], e_fft[k]);
      check($sformatf("u%0d frame_done", k), frame_done[k], e_done[k]);
      check($sformatf("u%0d win_move", k), win_move[k], e_move[k]);
      check($sformatf("u%0d busy", k), busy[k], ph[k] != 0);
      check($sformatf("u%0d frame_cnt", k), fcnt[k], cnt[k]);
      check($sformatf("u%0d error", k), error[k], err[k]);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic clear_hs();
    {stop_i, win_ready_i, ham_done_i, fft_done_i, pwr_consumed_i} = '0;
  endtask
  task automatic frame(input int g, input bit stop_in_fft);
    win_ready_i = 1; tick(); win_ready_i = 0; idle(g);
    ham_done_i = 1; tick(); ham_done_i = 0;
    if (stop_in_fft) begin stop_i = 1; tick(); stop_i = 0; end
    idle(g);
    fft_done_i = 1; tick(); fft_done_i = 0; idle(g);
    pwr_consumed_i = 1; tick(); pwr_consumed_i = 0; idle(3);
  endtask
  task automatic rand_run(input int n);
    repeat (n) begin
      run_i = $urandom_range(99) < 95;
      stop_i = $urandom_range(99) < 2;
      win_ready_i = $urandom_range(99) < 30;
      ham_done_i = $urandom_range(99) < 30;
      fft_done_i = $urandom_range(99) < 30;
      pwr_consumed_i = $urandom_range(99) < 30;
      win_idle_i = 1'($urandom_range(1));
      tick();
    end
    clear_hs();
  endtask
  initial begin
    idle(3);
    rst_n = 1; idle(2);
    run_i = 1; idle(9);
    frame(9, 0);
    idle(2);
    ham_done_i = 1; fft_done_i = 1; pwr_consumed_i = 1; tick(); clear_hs(); idle(2);
    win_ready_i = 1; tick(); win_ready_i = 0;
    fft_done_i = 1; pwr_consumed_i = 1; win_ready_i = 1; tick(); clear_hs(); idle(2);
    ham_done_i = 1; tick(); ham_done_i = 0; idle(2);
    fft_done_i = 1; tick(); fft_done_i = 0; idle(2);
    stop_i = 1; pwr_consumed_i = 1; tick(); clear_hs(); idle(4);
    frame(2, 0); frame(3, 0); frame(2, 1);
    idle(4);
    run_i = 1; tick(); idle(2);
    win_ready_i = 1; tick(); win_ready_i = 0; idle(2);
    ham_done_i = 1; tick(); ham_done_i = 0; idle(2);
    fft_done_i = 1; tick(); fft_done_i = 0; idle(500);
    pwr_consumed_i = 1; tick(); pwr_consumed_i = 0; idle(4);
    win_ready_i = 1; tick(); win_ready_i = 0; idle(2);
    ham_done_i = 1; tick(); ham_done_i = 0; idle(2);
    rst_n = 0; run_i = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d async busy", k), busy[k], 1'b0);
      check($sformatf("u%0d async cnt", k), fcnt[k], 0);
    end
    idle(2);
    rst_n = 1; tick();
    fft_done_i = 1; tick(); fft_done_i = 0; idle(3);
    run_i = 1; tick(); run_i = 1;
    win_ready_i = 1; tick(); win_ready_i = 0; run_i = 0;
    idle(WDT + 10);
    run_i = 1;
    repeat (10) frame(1, 0);
    rand_run(4000);
    run_i = 0; idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
